// File: rtl/full_adder_pkg.sv
// Shared arithmetic definitions for the full_adder datapath slice.
package full_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;

  // Two's-complement overflow from the carries into and out of the MSB.
  function automatic logic ovf_calc(input logic c_msb_in, input logic c_msb_out);
    return c_msb_in ^ c_msb_out;
  endfunction

endpackage

// File: rtl/full_adder_fa_cell.sv
// Single-bit full adder; the ripple-chain building block of full_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder with a live combinational result and a one-cycle
// registered copy carrying valid and signed-overflow flags.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s_q,
  output logic             co_q,
  output logic             ovf_q,
  output logic             out_valid
);

  logic             ovf;
  logic [WIDTH-1:0] s_d;
  logic             co_d;
  logic             ovf_d;
  logic             valid_d;
  logic             valid_q;

  // Each stage owns its carry-in/carry-out nets rather than sharing one
  // carry vector, so the chain is not a self-referencing bus.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic c_in;
    logic c_out;

    if (i == 0) begin : g_lsb
      assign c_in = ci;
    end else begin : g_mid
      assign c_in = g_bit[i-1].c_out;
    end

    fa_cell u_fa_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c_in),
      .s  (s[i]),
      .co (c_out)
    );
  end

  assign co  = g_bit[WIDTH-1].c_out;
  assign ovf = ovf_calc(g_bit[WIDTH-1].c_in, g_bit[WIDTH-1].c_out);

  always_comb begin
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    valid_d = in_valid;
    if (in_valid) begin
      s_d   = s;
      co_d  = co;
      ovf_d = ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1 and WIDTH=8.
module tb_full_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } res_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } vec8_t;

  logic clk;
  logic clk_en;
  logic rst;

  logic       a1, b1, ci1, in_valid1;
  logic       s1, co1, s_q1, co_q1, ovf_q1, out_valid1;

  logic [7:0] a8, b8, s8, s_q8;
  logic       ci8, in_valid8, co8, co_q8, ovf_q8, out_valid8;

  res_t q1[$];
  res_t q8[$];

  int checks;
  int errors;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .a         (a1),
    .b         (b1),
    .ci        (ci1),
    .s         (s1),
    .co        (co1),
    .in_valid  (in_valid1),
    .s_q       (s_q1),
    .co_q      (co_q1),
    .ovf_q     (ovf_q1),
    .out_valid (out_valid1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .a         (a8),
    .b         (b8),
    .ci        (ci8),
    .s         (s8),
    .co        (co8),
    .in_valid  (in_valid8),
    .s_q       (s_q8),
    .co_q      (co_q8),
    .ovf_q     (ovf_q8),
    .out_valid (out_valid8)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop one expected result whenever a DUT flags a new output.
  always @(posedge clk) begin
    #1;
    if (out_valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w1_unexpected_valid: got out_valid=1 expected empty scoreboard");
      end else begin
        res_t e;
        e = q1.pop_front();
        check("w1_reg", {29'd0, s_q1, co_q1, ovf_q1}, {29'd0, e.s[0], e.co, e.ovf});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (out_valid8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w8_unexpected_valid: got out_valid=1 expected empty scoreboard");
      end else begin
        res_t e;
        e = q8.pop_front();
        check("w8_reg", {22'd0, s_q8, co_q8, ovf_q8}, {22'd0, e.s, e.co, e.ovf});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] tt1 [8];
    vec8_t      bnd [4];
    logic [8:0] full;
    logic       exp_ovf;
    res_t       r;

    tt1 = '{5'b000_00, 5'b001_10, 5'b010_10, 5'b011_01,
            5'b111_11, 5'b100_10, 5'b101_01, 5'b110_01};
    bnd = '{'{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
            '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
            '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
            '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0}};

    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0; in_valid1 = 1'b0;
    a8 = '0;   b8 = '0;   ci8 = 1'b0; in_valid8 = 1'b0;

    #2 rst = 1'b1;
    #2;
    check("w1_reset", {28'd0, out_valid1, ovf_q1, co_q1, s_q1}, 32'd0);
    check("w8_reset", {21'd0, out_valid8, ovf_q8, co_q8, s_q8}, 32'd0);
    rst = 1'b0;

    // Exhaustive 1-bit truth table with the clock idle.
    for (int i = 0; i < 8; i++) begin
      logic [4:0] v;
      v = tt1[i];
      {a1, b1, ci1} = v[4:2];
      #50;
      check($sformatf("w1_comb_%b", v[4:2]), {30'd0, s1, co1}, {30'd0, v[1], v[0]});
    end
    check("w1_idle_no_valid", {31'd0, out_valid1}, 32'd0);

    clk_en = 1'b1;
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b0; in_valid1 = 1'b1;
    q1.push_back('{s: 8'd0, co: 1'b1, ovf: 1'b1});
    @(negedge clk);
    in_valid1 = 1'b0;
    a1 = 1'b0; b1 = 1'b0;
    @(negedge clk);
    check("w1_hold", {28'd0, out_valid1, s_q1, co_q1, ovf_q1}, {28'd0, 4'b0011});

    // WIDTH=8 boundary vectors, back to back.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a8 = bnd[i].a; b8 = bnd[i].b; ci8 = bnd[i].ci; in_valid8 = 1'b1;
      #1;
      check($sformatf("w8_bnd_comb_%0d", i), {23'd0, co8, s8}, {23'd0, bnd[i].co, bnd[i].s});
      q8.push_back('{s: bnd[i].s, co: bnd[i].co, ovf: bnd[i].ovf});
    end

    // Streaming a=0..3, b=1: out_valid must stay high every cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) check($sformatf("w8_stream_valid_%0d", i), {31'd0, out_valid8}, 32'd1);
      a8 = 8'(i); b8 = 8'd1; ci8 = 1'b0; in_valid8 = 1'b1;
      q8.push_back('{s: 8'(i + 1), co: 1'b0, ovf: 1'b0});
    end
    @(negedge clk);
    check("w8_stream_valid_4", {31'd0, out_valid8}, 32'd1);

    // Capture 0xAB, then reset asynchronously between edges.
    a8 = 8'hA0; b8 = 8'h0B; ci8 = 1'b0; in_valid8 = 1'b1;
    q8.push_back('{s: 8'hAB, co: 1'b0, ovf: 1'b0});
    @(negedge clk);
    in_valid8 = 1'b0;
    check("w8_pre_reset", {24'd0, s_q8}, 32'h0000_00AB);
    #2 rst = 1'b1;
    #1;
    check("w8_async_reset", {21'd0, out_valid8, ovf_q8, co_q8, s_q8}, 32'd0);
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1; in_valid8 = 1'b1;
    #1;
    check("w8_comb_in_reset", {23'd0, co8, s8}, {23'd0, 1'b0, 8'h47});
    @(posedge clk);
    #1;
    check("w8_reset_held", {21'd0, out_valid8, ovf_q8, co_q8, s_q8}, 32'd0);

    // First edge after release captures.
    @(negedge clk);
    rst = 1'b0;
    a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; in_valid8 = 1'b1;
    q8.push_back('{s: 8'h30, co: 1'b0, ovf: 1'b0});

    // Random vectors checked against arithmetic and the sign rule.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      ci8 = 1'($urandom_range(0, 1));
      in_valid8 = 1'b1;
      full = {1'b0, a8} + {1'b0, b8} + {8'd0, ci8};
      exp_ovf = (a8[7] == b8[7]) && (full[7] != a8[7]);
      #1;
      check("w8_rand_comb", {23'd0, co8, s8}, {23'd0, full});
      r = '{s: full[7:0], co: full[8], ovf: exp_ovf};
      q8.push_back(r);
    end

    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("w8_valid_drops", {31'd0, out_valid8}, 32'd0);
    check("w1_scoreboard_drained", q1.size(), 32'd0);
    check("w8_scoreboard_drained", q8.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
# full_adder

Parameterised ripple-carry full adder. Two ports serve two uses in the arithmetic datapath:
- A purely combinational result: sum and carry-out.
- A one-cycle registered copy with a valid flag and a signed-overflow flag, for pipelined consumers.

With the default WIDTH of 1 it is the classic 1-bit full adder. The combinational path works without any clock activity.

## Interface
Parameters:
- WIDTH, 1, operand and sum width in bits (≥1).

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock for the registered stage.
- rst  input  1  asynchronous, active-high reset of the registered stage.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in.
- s  output  WIDTH  combinational sum, (a+b+ci) mod 2^WIDTH.
- co  output  1  combinational carry-out, bit WIDTH of a+b+ci.
- in_valid  input  1  capture the current a/b/ci result at the next clk edge.
- s_q  output  WIDTH  registered sum.
- co_q  output  1  registered carry-out.
- ovf_q  output  1  registered two's-complement overflow.
- out_valid  output  1  s_q/co_q/ovf_q updated on the last edge.

## Operation
- Per bit i, with c[0]=ci:
  - s[i] = a[i]^b[i]^c[i]
  - c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i]
  - co = c[WIDTH]
- Unsigned semantics: {co,s} = a + b + ci exactly, WIDTH+1 bits, no truncation.
- Signed overflow: ovf = c[WIDTH] ^ c[WIDTH-1].
  - For WIDTH=1, c[0] is ci, so ovf = co ^ ci.
- s and co are pure functions of a, b and ci. They are independent of clk, rst and in_valid, and settle within the same delta/propagation time.
- Registered stage, on rising clk with in_valid=1: s_q←s, co_q←co, ovf_q←ovf, out_valid←1.
- Rising clk with in_valid=0: s_q, co_q and ovf_q hold their values; out_valid←0.
- X/Z on inputs is not handled specially; it propagates.

## Timing
- Combinational path: zero cycles. No registers between a/b/ci and s/co.
- Registered path: latency exactly 1 cycle. No backpressure and no ready signal. Back-to-back in_valid gives one result per cycle.
- Reset values, applied immediately on rst rising regardless of clk: s_q=0, co_q=0, ovf_q=0, out_valid=0.
- Reset held: registered outputs stay 0 and in_valid is ignored.
- Reset mid-operation: a capture pending on that edge is discarded.
- Reset release: the first edge after rst falls may capture, if in_valid=1.
- Combinational outputs remain live during reset.

## Structure
- Shared arithmetic package holds:
  - the default width constant (1);
  - an ovf_calc helper (function of carry into and out of the MSB).
- One sub-module, fa_cell: 1-bit full adder with ports a, b, ci, s, co. It is instantiated WIDTH times in a generate loop to form the ripple chain.
- Top level holds the carry chain wiring, the overflow XOR and a single always block with async reset for the output registers.

## Test plan
- WIDTH=1, clk idle, rst=0, steps 50 ns apart:
  - 000 → s=0, co=0
  - 001 → s=1, co=0
  - 010 → s=1, co=0
  - 011 → s=0, co=1
  - 111 → s=1, co=1
  - Then complete the exhaustive 8-case truth table: 100 → s=1, co=0; 101 → s=0, co=1; 110 → s=0, co=1.
- WIDTH=1 registered path: a=1, b=1, ci=0, in_valid=1, one edge → s_q=0, co_q=1, ovf_q=1, out_valid=1. Next edge with in_valid=0 → values held, out_valid=0.
- WIDTH=8 boundary cases:
  - a=0xFF, b=0x01, ci=0 → s=0x00, co=1, ovf=0
  - a=0x7F, b=0x01, ci=0 → s=0x80, co=0, ovf=1
  - a=0x80, b=0x80, ci=0 → s=0x00, co=1, ovf=1
  - a=0xFF, b=0xFF, ci=1 → s=0xFF, co=1, ovf=0
- Async reset: after a capture with s_q=0xAB, assert rst between edges → all registered outputs 0 before the next edge. s/co still track inputs.
- Streaming: in_valid high for 4 cycles with a=0..3, b=1, ci=0 → s_q=1, 2, 3, 4 on consecutive cycles, out_valid continuously 1.
- Random (WIDTH=8, 1000 vectors): {co,s} equals a+b+ci. ovf_q matches the sign rule one cycle later.
